// File: rtl/noc_pkg.sv
// noc_pkg: shared mesh-node constants and arbiter state encoding
package noc_pkg;
   localparam int NORTH      = 0;
   localparam int SOUTH      = 1;
   localparam int EAST       = 2;
   localparam int WEST       = 3;
   localparam int LOCAL      = 4;
   localparam int NODE_PORTS = 5;
   localparam int NOC_FLIT_W = 32;
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/noc_out_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit scanning upward from rr_ptr (mod N)
//   req    - request vector
//   rr_ptr - scan start index
//   any    - at least one request set
//   winner - index of the chosen requester (0 when any=0)
module rr_pick #(
   parameter int N     = 5,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             any,
   output logic [IDX_W-1:0] winner
);
   // Scanning from the far end means the last hit written is the nearest one to rr_ptr.
   always_comb begin
      any    = |req;
      winner = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(rr_ptr) + i) % N]) winner = IDX_W'((int'(rr_ptr) + i) % N);
      end
   end
endmodule

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: per-output-port round-robin switch allocator with wormhole packet locking
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/last/data  - per-requester flit offer
//   in_ready            - per-requester accept (only the lock holder, mirrors out_ready)
//   out_valid/last/data - output link flit, muxed from the lock holder
//   out_ready           - downstream accept
//   owner, locked       - current lock holder and lock status
module noc_out_arbiter import noc_pkg::*; #(
   parameter int N_REQ  = NODE_PORTS,
   parameter int FLIT_W = NOC_FLIT_W,
   parameter int IDX_W  = $clog2(N_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_REQ-1:0]               in_valid,
   input  logic [N_REQ-1:0]               in_last,
   input  logic [N_REQ-1:0][FLIT_W-1:0]   in_data,
   output logic [N_REQ-1:0]               in_ready,
   output logic                           out_valid,
   output logic                           out_last,
   output logic [FLIT_W-1:0]              out_data,
   input  logic                           out_ready,
   output logic [IDX_W-1:0]               owner,
   output logic                           locked
);
   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, winner;
   logic             any;

   rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req    (in_valid),
      .rr_ptr (rr_ptr_q),
      .any    (any),
      .winner (winner)
   );

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      locked    = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      in_ready  = '0;
      if (state_q == ARB_IDLE) begin
         state_d = any ? ARB_LOCKED : ARB_IDLE;
         owner_d = any ? winner : owner_q;
      end else begin
         locked            = 1'b1;
         out_valid         = in_valid[owner_q];
         out_last          = in_last[owner_q];
         out_data          = in_data[owner_q];
         in_ready[owner_q] = out_ready;
         // Explicit wrap keeps the pointer inside 0..N_REQ-1 for non-power-of-2 N_REQ.
         if (out_valid && out_ready && out_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   assign owner = owner_q;
endmodule

// File: tb/tb_noc_out_arbiter.sv
// tb_noc_out_arbiter: directed checks of reset, locking, round-robin order, backpressure and 3-port wrap
module tb_noc_out_arbiter;
   import noc_pkg::*;
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [4:0]       in_valid, in_last, in_ready;
   logic [4:0][31:0] in_data;
   logic             out_valid, out_last, out_ready, locked;
   logic [31:0]      out_data;
   logic [2:0]       owner;
   logic [2:0]       v3, l3, rdy3;
   logic [2:0][31:0] d3;
   logic             ov3, ol3, lk3;
   logic [31:0]      od3;
   logic [1:0]       ow3;
   int               checks = 0;
   int               failures = 0;

   always #5 clk = ~clk;

   noc_out_arbiter dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
      .out_ready(out_ready), .owner(owner), .locked(locked)
   );

   noc_out_arbiter #(.N_REQ(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_last(l3), .in_data(d3),
      .in_ready(rdy3), .out_valid(ov3), .out_last(ol3), .out_data(od3),
      .out_ready(1'b1), .owner(ow3), .locked(lk3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      v3        = '0;
      l3        = '0;
      d3        = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      tick();
      checks++;
      if ({locked, owner, out_valid, in_ready} !== 10'b0) begin
         failures++;
         $display("FAIL reset_outputs got locked=%0b owner=%0d out_valid=%0b in_ready=%b exp all 0", locked, owner, out_valid, in_ready);
      end
      checks++;
      if (dut.rr_ptr_q !== 3'd0) begin
         failures++;
         $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr_q);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      in_valid = 5'b00100; in_data[EAST] = 32'h201; out_ready = 1'b1;
      tick();
      tick();
      in_data[EAST] = 32'h202;
      #1;
      checks++;
      if ({locked, owner} !== {1'b1, 3'd2}) begin
         failures++;
         $display("FAIL rstmid_pre got locked=%0b owner=%0d exp locked=1 owner=2", locked, owner);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({locked, owner, out_valid} !== 5'b0 || dut.rr_ptr_q !== 3'd0) begin
         failures++;
         $display("FAIL rstmid_after got locked=%0b owner=%0d out_valid=%0b rr=%0d exp 0 0 0 0", locked, owner, out_valid, dut.rr_ptr_q);
      end
      in_valid = 5'b00010; in_last = 5'b00010; in_data[SOUTH] = 32'h101;
      tick();
      checks++;
      if ({locked, owner, out_data} !== {1'b1, 3'd1, 32'h101}) begin
         failures++;
         $display("FAIL rstmid_new got locked=%0b owner=%0d data=%0h exp 1 1 101", locked, owner, out_data);
      end
   endtask

   task automatic test_single;
      do_reset();
      in_valid = 5'b01000; in_data[WEST] = 32'h301; out_ready = 1'b1;
      #1;
      checks++;
      if ({locked, out_valid, in_ready} !== 7'b0) begin
         failures++;
         $display("FAIL single_arb got locked=%0b out_valid=%0b in_ready=%b exp 0 0 0", locked, out_valid, in_ready);
      end
      tick();
      for (int f = 1; f <= 4; f++) begin
         in_data[WEST] = 32'h300 + f;
         in_last[WEST] = (f == 4);
         #1;
         checks++;
         if ({locked, owner, out_valid, out_last, in_ready, out_data} !== {1'b1, 3'd3, 1'b1, f == 4, 5'b01000, 32'h300 + f}) begin
            failures++;
            $display("FAIL single_flit%0d got locked=%0b owner=%0d v=%0b last=%0b rdy=%b data=%0h exp owner=3 data=%0h", f, locked, owner, out_valid, out_last, in_ready, out_data, 32'h300 + f);
         end
         tick();
      end
      in_valid = '0;
      #1;
      checks++;
      if (locked !== 1'b0 || dut.rr_ptr_q !== 3'd4) begin
         failures++;
         $display("FAIL single_end got locked=%0b rr=%0d exp 0 4", locked, dut.rr_ptr_q);
      end
   endtask

   task automatic test_round_robin;
      do_reset();
      in_valid = 5'b11111; in_last = 5'b11111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) in_data[i] = 32'hA0 + i;
      #1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (locked !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle%0d got locked=%0b exp 0", k, locked);
         end
         tick();
         checks++;
         if ({locked, owner, out_data} !== {1'b1, 3'(k % 5), 32'hA0 + k % 5}) begin
            failures++;
            $display("FAIL rr_grant%0d got locked=%0b owner=%0d data=%0h exp owner=%0d", k, locked, owner, out_data, k % 5);
         end
         tick();
      end
   endtask

   task automatic test_wormhole;
      do_reset();
      in_valid = 5'b00001; in_last = 5'b00001; out_ready = 1'b1;
      tick();
      tick();
      in_valid = 5'b00011; in_data[NORTH] = 32'h0F; in_data[SOUTH] = 32'h11;
      tick();
      for (int f = 1; f <= 3; f++) begin
         in_data[SOUTH] = 32'h10 + f;
         in_last[SOUTH] = (f == 3);
         #1;
         checks++;
         if ({owner, in_ready, out_data, out_last} !== {3'd1, 5'b00010, 32'h10 + f, f == 3}) begin
            failures++;
            $display("FAIL worm_flit%0d got owner=%0d rdy=%b data=%0h last=%0b exp owner=1 rdy=00010 data=%0h", f, owner, in_ready, out_data, out_last, 32'h10 + f);
         end
         tick();
      end
      in_valid = 5'b00001;
      #1;
      checks++;
      if (locked !== 1'b0 || dut.rr_ptr_q !== 3'd2) begin
         failures++;
         $display("FAIL worm_release got locked=%0b rr=%0d exp 0 2", locked, dut.rr_ptr_q);
      end
      tick();
      checks++;
      if ({locked, owner, in_ready} !== {1'b1, 3'd0, 5'b00001}) begin
         failures++;
         $display("FAIL worm_wrap got locked=%0b owner=%0d rdy=%b exp 1 0 00001", locked, owner, in_ready);
      end
   endtask

   task automatic test_backpressure;
      logic [5:0] rpat = 6'b111001;
      logic [5:0] vpat = 6'b110111;
      int idx = 0;
      do_reset();
      in_valid = 5'b00100; in_data[EAST] = 32'h21;
      tick();
      for (int c = 0; c < 6; c++) begin
         in_valid[EAST] = vpat[c];
         out_ready      = rpat[c];
         in_data[EAST]  = 32'h21 + idx;
         in_last[EAST]  = (idx == 2);
         #1;
         checks++;
         if ({locked, out_valid, in_ready[EAST]} !== {1'b1, vpat[c], rpat[c]} || (vpat[c] && out_data !== 32'h21 + idx)) begin
            failures++;
            $display("FAIL bp_cycle%0d got locked=%0b v=%0b rdy=%0b data=%0h exp 1 %0b %0b data=%0h", c, locked, out_valid, in_ready[EAST], out_data, vpat[c], rpat[c], 32'h21 + idx);
         end
         if (vpat[c] && rpat[c]) idx++;
         tick();
      end
      in_valid = '0;
      #1;
      checks++;
      if (idx !== 3 || locked !== 1'b0 || dut.rr_ptr_q !== 3'd3) begin
         failures++;
         $display("FAIL bp_end got flits=%0d locked=%0b rr=%0d exp 3 0 3", idx, locked, dut.rr_ptr_q);
      end
   endtask

   task automatic test_npow2;
      do_reset();
      v3 = 3'b111; l3 = 3'b111;
      for (int i = 0; i < 3; i++) d3[i] = 32'hC0 + i;
      #1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({lk3, ow3, od3} !== {1'b1, 2'(k % 3), 32'hC0 + k % 3}) begin
            failures++;
            $display("FAIL np2_grant%0d got locked=%0b owner=%0d data=%0h exp owner=%0d", k, lk3, ow3, od3, k % 3);
         end
         tick();
         checks++;
         if (dut3.rr_ptr_q !== 2'((k + 1) % 3)) begin
            failures++;
            $display("FAIL np2_rr%0d got=%0d exp=%0d", k, dut3.rr_ptr_q, (k + 1) % 3);
         end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_reset_mid();
      test_single();
      test_round_robin();
      test_wormhole();
      test_backpressure();
      test_npow2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
